fetch_unit: RTL



---
 rtl/riscv_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for fetch, decode and imm_gen.
package riscv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned ILEN     = 32;
   localparam int unsigned OPCODE_W = 7;

   localparam logic [OPCODE_W-1:0] ITYPEALO = 7'b0010011;
   localparam logic [OPCODE_W-1:0] LOAD     = 7'b0000011;
   localparam logic [OPCODE_W-1:0] STORE    = 7'b0100011;
   localparam logic [OPCODE_W-1:0] BRANCH   = 7'b1100011;
   localparam logic [OPCODE_W-1:0] JAL      = 7'b1101111;
   localparam logic [OPCODE_W-1:0] JALR     = 7'b1100111;
   localparam logic [OPCODE_W-1:0] LUI      = 7'b0110111;
   localparam logic [OPCODE_W-1:0] AUIPC    = 7'b0010111;

   // One buffered fetch: the instruction word together with the PC it came from
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
module sync_fifo #(
   parameter int unsigned  WIDTH = 32,
   parameter int unsigned  DEPTH = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign count    = count_q;
   assign pop_data = mem[rd_ptr_q];

   // A pop frees the slot a simultaneous push needs, so push-while-full is allowed with a pop
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Occupancy next state
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage write; no reset needed, validity is tracked by the count
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   // Pointers and count; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, response buffer, redirect flush.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [XLEN-1:0]     imem_req_addr,
   input  logic                imem_rsp_valid,
   input  logic [ILEN-1:0]     imem_rsp_data,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output logic [ILEN-1:0]     out_inst,
   output logic [OPCODE_W-1:0] out_opcode,
   output logic [11:0]         out_imm
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic [CNT_W-1:0] fifo_count, pcq_count;
   logic             fifo_empty, fifo_full, pcq_empty, pcq_full;
   fetch_entry_t     fifo_head, fifo_in;
   logic [XLEN-1:0]  pcq_head;

   logic credit, req_fire, rsp_take, rsp_keep, pop_fire;
   logic unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Buffered entries plus fetches still in flight may never exceed the buffer size
   assign credit = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(DEPTH);

   assign imem_req_valid = rst_n && credit && !redirect_valid;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a memory protocol error and is ignored
   assign rsp_take = imem_rsp_valid && (outstanding_q != '0);
   // Stale responses (older than a redirect) are counted off by drop_q
   assign rsp_keep = rsp_take && (drop_q == '0) && !redirect_valid;
   assign pop_fire = out_valid && out_ready && !redirect_valid;

   assign fifo_in = '{pc: pcq_head, inst: imem_rsp_data};

   // Next-state for PC, in-flight count and stale-response count
   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
      drop_d        = drop_q;
      if (redirect_valid) begin
         pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
         // Everything still in flight after this cycle belongs to the old stream
         drop_d = outstanding_q - CNT_W'(rsp_take);
      end else begin
         if (req_fire) pc_d = pc_q + XLEN'(4);
         if (rsp_take && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   // PCs of live (non-stale) requests, matched in order to their responses
   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_pc_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (req_fire),
      .push_data (pc_q),
      .pop       (rsp_keep),
      .pop_data  (pcq_head),
      .empty     (pcq_empty),
      .full      (pcq_full),
      .count     (pcq_count)
   );

   // Instructions waiting for decode
   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_inst_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (rsp_keep),
      .push_data (fifo_in),
      .pop       (pop_fire),
      .pop_data  (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign out_valid = !fifo_empty;

   // Present the head entry; fields read as zero while nothing is buffered
   always_comb begin
      out_pc   = '0;
      out_inst = '0;
      if (!fifo_empty) begin
         out_pc   = fifo_head.pc;
         out_inst = fifo_head.inst;
      end
   end

   assign out_opcode = out_inst[OPCODE_W-1:0];
   assign out_imm    = out_inst[31:20];

   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (outstanding_q != '0));
   a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
      outstanding_q <= CNT_W'(DEPTH));
   a_pcq_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
      pcq_count == (outstanding_q - drop_q));
   a_pcq_space: assert property (@(posedge clk) disable iff (!rst_n)
      req_fire |-> !pcq_full);
   a_pcq_head: assert property (@(posedge clk) disable iff (!rst_n)
      rsp_keep |-> !pcq_empty);
   a_fifo_space: assert property (@(posedge clk) disable iff (!rst_n)
      rsp_keep |-> (!fifo_full || pop_fire));

endmodule
